// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and baud divisor helper.
// Used by both the receive and transmit halves of the link.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    function automatic int unsigned baud_cnt(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// The reset value is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte valid/ready holding register.
// Reports framing errors and overruns as single-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned BAUD_CNT = baud_cnt(CLK_FREQ, BAUD);
    localparam int unsigned HALF_CNT = BAUD_CNT / 2;
    localparam int unsigned CW       = $clog2(BAUD_CNT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CNT - 1);

    logic          rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_reg, shift_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n, ovr_n;
    logic          armed, armed_n;
    logic          tick;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            armed     <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
            overrun   <= ovr_n;
            armed     <= armed_n;
        end
    end

    assign busy = (state != IDLE);
    assign tick = (cnt == '0);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        data_n    = data;
        valid_n   = valid & ~ready;
        ferr_n    = 1'b0;
        ovr_n     = 1'b0;
        armed_n   = armed;

        case (state)
            IDLE: begin
                // A break leaves armed clear until the line has been seen idle.
                if (rx_s) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    state_n = START;
                    cnt_n   = HALF_LOAD;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    cnt_n     = FULL_LOAD;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    shift_n = {rx_s, shift_reg[7:1]};
                    cnt_n   = FULL_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    state_n = IDLE;
                    if (!rx_s) begin
                        ferr_n  = 1'b1;
                        armed_n = 1'b0;
                    end else if (!valid || ready) begin
                        // A load in the accept cycle wins over the clear.
                        data_n  = shift_reg;
                        valid_n = 1'b1;
                    end else begin
                        ovr_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame driver with a byte-level outcome model
// feeding a scoreboard queue, checked by an independent output monitor.
module tb_uart_rx;

    localparam int BC   = 10;
    localparam int HALF = BC / 2;
    // Pin edge to registered output: 2 sync flops, 1 IDLE cycle, half bit, 9 full bits.
    localparam int LAT  = 2 + 1 + HALF + 9 * BC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, busy, frame_err, overrun;

    uart_rx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         kind;  // 0 byte presented, 1 framing error, 2 overrun
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t q[$];
    bit   hold_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop, input int n);
        exp_t e;
        e.data = b;
        e.at   = n + LAT;
        if (!stop) begin
            e.kind = 1;
        end else if (hold_full && !ready) begin
            e.kind = 2;
        end else begin
            e.kind    = 0;
            hold_full = !ready;
        end
        q.push_back(e);
    endtask

    task automatic wait_bit();
        repeat (BC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int abort_bit, input bit brk);
        int n;
        n  = cyc;
        rx = 1'b0;
        if (abort_bit < 0) model_frame(b, stop, n);
        wait_bit();
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            if (k == abort_bit) begin
                repeat (HALF) @(posedge clk);
                #1;
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n     = 1'b1;
                rx        = 1'b1;
                hold_full = 1'b0;
                chk("rst_valid", valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_data", data, 0);
                chk("rst_frame_err", frame_err, 0);
                chk("rst_overrun", overrun, 0);
                repeat (3) wait_bit();
                return;
            end
            wait_bit();
        end
        rx = stop;
        wait_bit();
        if (!stop) begin
            if (brk) repeat (30) wait_bit();
            rx = 1'b1;
            wait_bit();
        end
    endtask

    task automatic check_event(input int kind, input logic [7:0] d);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=kind%0d data=%0h expected=none (cycle %0d)", kind, d, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.at);
            if (kind == 0 && e.kind == 0) chk("event_data", d, e.data);
        end
    endtask

    // Monitor: a new byte is one that appears when the register was empty or just accepted.
    bit         prev_valid = 1'b0;
    bit         prev_acc = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (prev_valid && !prev_acc) chk("data_stable", data, prev_data);
            else check_event(0, data);
        end
        if (frame_err === 1'b1) check_event(1, 8'h00);
        if (overrun === 1'b1) check_event(2, 8'h00);
        prev_valid = (valid === 1'b1);
        prev_acc   = prev_valid && (ready === 1'b1);
        prev_data  = data;
    end

    initial begin
        logic [7:0] b;
        bit         stop;
        int         n;

        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_data", data, 0);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        send_frame(8'hA5, 1'b1, -1, 1'b0);
        wait_bit();

        send_frame(8'h00, 1'b1, -1, 1'b0);
        send_frame(8'hFF, 1'b1, -1, 1'b0);
        send_frame(8'h55, 1'b1, -1, 1'b0);
        wait_bit();

        ready = 1'b0;
        send_frame(8'h3C, 1'b1, -1, 1'b0);
        send_frame(8'hC3, 1'b1, -1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("ovr_hold_valid", valid, 1);
        chk("ovr_hold_data", data, 8'h3C);
        ready     = 1'b1;
        hold_full = 1'b0;
        @(posedge clk);
        #1;
        chk("ovr_accept_clears", valid, 0);
        wait_bit();

        send_frame(8'h81, 1'b0, -1, 1'b1);
        wait_bit();

        n  = cyc;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy_rise", busy, 1);
        repeat (4) @(negedge clk);
        chk("glitch_busy_at_check", busy, 1);
        @(negedge clk);
        chk("glitch_busy_fall", busy, 0);
        chk("glitch_timing", cyc, n + 3 + HALF);
        @(posedge clk);
        #1;
        wait_bit();

        send_frame(8'h5A, 1'b1, 4, 1'b0);
        send_frame(8'h7E, 1'b1, -1, 1'b0);
        wait_bit();

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ready = ~ready;
                if (ready) hold_full = 1'b0;
            end
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(b, stop, -1, 1'b0);
        end
        ready     = 1'b1;
        hold_full = 1'b0;

        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the board UART link: an 8N1 asynchronous serial receiver that deserialises bytes arriving from the laptop (FTDI TX) into parallel data. The block presents each byte to downstream logic through a valid/ready handshake, for example to the bitonic-sort input loader. It also flags framing errors and overruns. It is baud-compatible with `uart_tx` when both use the same `CLK_FREQ`/`BAUD`.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate. `BAUD_CNT = CLK_FREQ/BAUD` (integer division). `HALF_CNT = BAUD_CNT/2`. `BAUD_CNT` must be ≥ 4.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `rx`  in  1  asynchronous serial line; idle high.
- `data`  out  8  received byte; stable while `valid`=1.
- `valid`  out  1  a byte is held in `data`.
- `ready`  in  1  consumer accepts the byte; transfer occurs when `valid & ready`.
- `busy`  out  1  a frame is being received (state ≠ IDLE).
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while the holding register was still full.

## Operation
- `rx` passes through a 2-flop synchroniser, `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- `armed` flag:
  - Reset value is 1.
  - Cleared on a framing error.
  - Set again after `rx_s` has been seen high for one cycle in IDLE.
  - Start detection requires `armed`, so a held-low line (break) produces only one `frame_err`.
- State machine: IDLE → START → DATA → STOP → IDLE.
  - **IDLE:** when `armed & rx_s==0`, go to START and load `baud_cnt = HALF_CNT-1`.
  - **START:** count down. At 0, sample `rx_s`:
    - 1: glitch. Return to IDLE with no output.
    - 0: go to DATA, set `bit_idx=0`, load `baud_cnt = BAUD_CNT-1`.
  - **DATA:** at count 0, shift `rx_s` into bit 7 of `shift_reg` (shift right, LSB first) and reload `BAUD_CNT-1`. After the sample with `bit_idx==7`, go to STOP. Otherwise increment `bit_idx`.
  - **STOP:** at count 0, sample `rx_s` and go to IDLE.
    - 1, holding register empty (or emptying this cycle): load `data ← shift_reg`, set `valid`.
    - 1, holding register full: pulse `overrun`. Keep the old byte; drop the new one.
    - 0: pulse `frame_err`, clear `armed`, leave `data`/`valid` unchanged.
- Handshake:
  - `valid` clears on the cycle after `valid & ready`.
  - If accept and a new load happen in the same cycle, the load wins: `valid` stays 1 with the new byte, and no overrun is raised.
  - `ready` has no effect while `valid`=0.
- Reset, at any time including mid-frame: state=IDLE, `data`=0, `valid`=0, `busy`=0, `frame_err`=0, `overrun`=0, `armed`=1, counters 0. Any partial frame is discarded.

## Timing
- Define t as the cycle in which IDLE sees `rx_s==0`. `rx_s` lags the pin by 2 cycles.
- Sample points:
  - Start-bit check: t+HALF_CNT.
  - Data bit k (k=0..7): t+HALF_CNT+(k+1)·BAUD_CNT.
  - Stop bit: t+HALF_CNT+9·BAUD_CNT.
- `valid`, `frame_err` and `overrun` are registered and assert in the cycle after the stop sample.
- `busy` is high from t+1 through the stop-sample cycle.
- The block returns to IDLE mid-stop-bit, so back-to-back frames with a single stop bit are received without loss.
- Tolerance: the ±half-bit sampling window gives about ±4.5% total baud mismatch over 10 bits.

## Structure
- Shared package `uart_pkg`:
  - `state_t` enum (IDLE, START, DATA, STOP), reused by `uart_tx`.
  - Function `baud_cnt(clk_freq, baud)`.
- One sub-module: `sync_2ff` (parameterised width, reset value 1), reusable for other asynchronous inputs.
- Counter width is `$clog2(BAUD_CNT)`.

## Test plan
All scenarios use `CLK_FREQ=1000`, `BAUD=100` (`BAUD_CNT=10`, `HALF_CNT=5`) and drive `rx` through a bit-accurate model.
- Send 0xA5 with `ready`=1 → `valid` pulses for one cycle with `data`=0xA5, at t+96 (one cycle after the stop sample at t+95); `frame_err`=0.
- Send 0x00, 0xFF, 0x55 back-to-back, one stop bit each, `ready`=1 → three valid pulses in order, no errors.
- Hold `ready`=0; send 0x3C then 0xC3 → `data` stays 0x3C, `valid` stays 1, `overrun` pulses once at the end of the second frame. Raising `ready` then clears `valid`.
- Send 0x81 with the stop bit forced low, then hold the line low for 30 bit times → exactly one `frame_err` pulse, no `valid`, no new frame until the line returns high.
- 3-cycle low glitch on idle `rx` → `busy` pulses, and the FSM returns to IDLE at the start-bit check with no outputs.
- Assert `rst_n`=0 for one cycle during data bit 4, then send 0x7E → no output from the aborted frame; 0x7E is received correctly.
